// File: rtl/aegnn_pkg.sv
// Shared graph_conv widths plus the tag type used to track BAQ result ownership.
package aegnn;
    localparam int B_WIDTH = 16;
    localparam int F_WIDTH = 8;
    localparam int MAX_REQ = 4;

    function automatic int clog2_safe(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Requester ids are sized for MAX_REQ; a scheduler instance must use N_REQ <= 2**IDW.
    localparam int IDW = clog2_safe(MAX_REQ);

    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
    } baq_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);
    int idx;

    // Walk from the farthest offset back to ptr so the closest requester wins last.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/baq_scheduler.sv
// Shares one BAQ datapath between N_REQ aggregation engines with round-robin issue,
// a tag pipe aligned to BAQ latency and a credit-guarded response FIFO.
module baq_scheduler
    import aegnn::*;
#(
    parameter int OUT_C      = 32,
    parameter int N_REQ      = 4,
    parameter int BAQ_LAT    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_REQ*OUT_C*B_WIDTH-1:0] req_pack,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    output logic [OUT_C*B_WIDTH-1:0]     aggr_pack,
    output logic                         aggr_valid,
    input  logic [OUT_C*F_WIDTH-1:0]     conv_out_pack,
    input  logic                         conv_out_valid,
    output logic [OUT_C*F_WIDTH-1:0]     rsp_pack,
    output logic [N_REQ-1:0]             rsp_valid,
    input  logic [N_REQ-1:0]             rsp_ready,
    output logic                         err_sticky
);
    localparam int BW = OUT_C * B_WIDTH;
    localparam int FW = OUT_C * F_WIDTH;
    localparam int AW = clog2_safe(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [IDW-1:0]   ptr;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   gid;
    logic [CW-1:0]    credits;
    logic             hs;

    baq_tag_t tag_pipe [BAQ_LAT+1];
    baq_tag_t tail;

    logic [IDW-1:0] fifo_id   [FIFO_DEPTH];
    logic [FW-1:0]  fifo_data [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic [IDW-1:0] head_id;
    logic           push;
    logic           pop;

    rr_arbiter #(.N(N_REQ), .PW(IDW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        gid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) gid = IDW'(i);
        end
    end

    // A grant only becomes a ready strobe while a FIFO slot is reserved for its result.
    assign req_ready = (credits != '0) ? grant : '0;
    assign hs        = |req_ready;

    assign tail       = tag_pipe[BAQ_LAT];
    assign push       = tail.v;
    assign fifo_empty = (fifo_count == '0);
    assign head_id    = fifo_id[rd_ptr];
    assign pop        = !fifo_empty && rsp_ready[head_id];
    assign rsp_valid  = fifo_empty ? '0 : (N_REQ'(1) << head_id);
    assign rsp_pack   = fifo_empty ? '0 : fifo_data[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr        <= '0;
            aggr_valid <= 1'b0;
            aggr_pack  <= '0;
            for (int k = 0; k <= BAQ_LAT; k++) tag_pipe[k] <= '0;
        end else begin
            aggr_valid <= hs;
            if (hs) begin
                aggr_pack <= req_pack[int'(gid)*BW +: BW];
                ptr       <= (gid == IDW'(N_REQ - 1)) ? '0 : gid + 1'b1;
            end
            tag_pipe[0] <= '{v: hs, id: gid};
            for (int k = 1; k <= BAQ_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    // Capture follows the tag, not conv_out_valid, so a stray BAQ pulse can never overfill the FIFO.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            credits    <= CW'(FIFO_DEPTH);
            err_sticky <= 1'b0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            credits    <= credits - CW'(hs) + CW'(pop);
            if (conv_out_valid != tail.v) err_sticky <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr]   <= tail.id;
            fifo_data[wr_ptr] <= conv_out_pack;
        end
    end
endmodule

// File: tb/tb_baq_scheduler.sv
// Directed bench for baq_scheduler: BAQ latency model, rr/credit model and an in-order response scoreboard.
module tb_baq_scheduler;
    import aegnn::*;

    localparam int OUT_C      = 32;
    localparam int N_REQ      = 4;
    localparam int BAQ_LAT    = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int BW         = OUT_C * B_WIDTH;
    localparam int FW         = OUT_C * F_WIDTH;
    localparam int CMPW       = BW;

    logic                   clk  = 1'b0;
    logic                   rstn = 1'b0;
    logic [N_REQ*BW-1:0]    req_pack = '0;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [BW-1:0]          aggr_pack;
    logic                   aggr_valid;
    logic [FW-1:0]          conv_out_pack;
    logic                   conv_out_valid;
    logic [FW-1:0]          rsp_pack;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready = '0;
    logic                   err_sticky;

    logic                   inject = 1'b0;
    logic [BAQ_LAT-1:0]     baq_v = '0;
    logic [FW-1:0]          baq_d [BAQ_LAT];

    typedef struct {
        int            id;
        logic [FW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    int            grant_log[$];
    int            compared   = 0;
    int            mismatched = 0;
    int            exp_ptr    = 0;
    int            hs_count   = 0;
    logic [BW-1:0] t1_pack;
    int            t2_exp [4] = '{1, 2, 3, 0};

    baq_scheduler #(
        .OUT_C(OUT_C), .N_REQ(N_REQ), .BAQ_LAT(BAQ_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_pack       (req_pack),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .aggr_pack      (aggr_pack),
        .aggr_valid     (aggr_valid),
        .conv_out_pack  (conv_out_pack),
        .conv_out_valid (conv_out_valid),
        .rsp_pack       (rsp_pack),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .err_sticky     (err_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] quant(input logic [BW-1:0] a);
        logic [FW-1:0] q;
        q = '0;
        for (int e = 0; e < OUT_C; e++) q[e*F_WIDTH +: F_WIDTH] = a[e*B_WIDTH +: F_WIDTH];
        return q;
    endfunction

    // BAQ stand-in: fixed latency, keeps the low bits of every channel, ignores scheduler reset.
    always @(posedge clk) begin
        baq_v    <= {baq_v[BAQ_LAT-2:0], aggr_valid};
        baq_d[0] <= quant(aggr_pack);
        for (int k = 1; k < BAQ_LAT; k++) baq_d[k] <= baq_d[k-1];
    end
    assign conv_out_valid = baq_v[BAQ_LAT-1] | inject;
    assign conv_out_pack  = baq_d[BAQ_LAT-1];

    function automatic logic [N_REQ-1:0] rrModel(input logic [N_REQ-1:0] v, input int p);
        for (int i = 0; i < N_REQ; i++) begin
            if (v[(p + i) % N_REQ]) return N_REQ'(1) << ((p + i) % N_REQ);
        end
        return '0;
    endfunction

    task automatic checkOutput(input string tag, input logic [CMPW-1:0] observed,
                               input logic [CMPW-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] valid, input logic [N_REQ-1:0] ready);
        req_valid = valid;
        rsp_ready = ready;
        for (int r = 0; r < N_REQ * OUT_C; r++) req_pack[r*B_WIDTH +: B_WIDTH] = B_WIDTH'($urandom);
        #1;
    endtask

    // One clock: check arbitration against the model, log handshakes, score the FIFO head.
    task automatic cycle();
        logic [N_REQ-1:0] exp_ready;
        logic [N_REQ-1:0] hs;
        @(negedge clk);
        exp_ready = (sb.size() < FIFO_DEPTH) ? rrModel(req_valid, exp_ptr) : '0;
        checkOutput("req_ready", CMPW'(req_ready), CMPW'(exp_ready));
        hs = req_valid & req_ready;
        for (int g = 0; g < N_REQ; g++) begin
            if (hs[g]) begin
                sb.push_back('{id: g, data: quant(req_pack[g*BW +: BW])});
                grant_log.push_back(g);
                hs_count++;
                exp_ptr = (g + 1) % N_REQ;
            end
        end
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                checkOutput("rsp_unexpected", CMPW'(rsp_valid), '0);
            end else begin
                checkOutput("rsp_owner", CMPW'(rsp_valid), CMPW'(N_REQ'(1) << sb[0].id));
                checkOutput("rsp_data", CMPW'(rsp_pack), CMPW'(sb[0].data));
                if (rsp_ready[sb[0].id]) void'(sb.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            cycle();
            n++;
        end
        checkOutput("drain_timeout", CMPW'(sb.size()), '0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus('0, '0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_aggr_valid", CMPW'(aggr_valid), '0);
        checkOutput("rst_aggr_pack", CMPW'(aggr_pack), '0);
        checkOutput("rst_rsp_valid", CMPW'(rsp_valid), '0);
        checkOutput("rst_rsp_pack", CMPW'(rsp_pack), '0);
        checkOutput("rst_err", CMPW'(err_sticky), '0);
        rstn = 1'b1;

        $display("[TB] test 1: single request latency");
        applyStimulus(4'b0001, 4'b1111);
        checkOutput("t1_ready", CMPW'(req_ready), CMPW'(4'b0001));
        t1_pack = req_pack[BW-1:0];
        cycle();
        applyStimulus('0, 4'b1111);
        checkOutput("t1_aggr_valid", CMPW'(aggr_valid), CMPW'(1'b1));
        checkOutput("t1_aggr_pack", CMPW'(aggr_pack), CMPW'(t1_pack));
        checkOutput("t1_rsp_early", CMPW'(rsp_valid), '0);
        cycle();
        checkOutput("t1_aggr_drop", CMPW'(aggr_valid), '0);
        checkOutput("t1_aggr_hold", CMPW'(aggr_pack), CMPW'(t1_pack));
        repeat (3) begin
            checkOutput("t1_rsp_early", CMPW'(rsp_valid), '0);
            cycle();
        end
        checkOutput("t1_rsp_valid", CMPW'(rsp_valid), CMPW'(4'b0001));
        checkOutput("t1_rsp_data", CMPW'(rsp_pack), CMPW'(quant(t1_pack)));
        waitDrain(10);

        $display("[TB] test 2: all requesters, consumer ready");
        grant_log.delete();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'b1111, 4'b1111);
            cycle();
        end
        applyStimulus('0, 4'b1111);
        waitDrain(20);
        checkOutput("t2_grant_count", CMPW'(grant_log.size() >= 8), CMPW'(1'b1));
        if (grant_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) checkOutput("t2_grant_order", CMPW'(grant_log[i]), CMPW'(t2_exp[i]));
        end
        checkOutput("t2_err", CMPW'(err_sticky), '0);

        $display("[TB] test 3: consumer stalled, credits exhaust");
        hs_count = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b1111, 4'b0000);
            cycle();
        end
        checkOutput("t3_handshakes", CMPW'(hs_count), CMPW'(FIFO_DEPTH));
        checkOutput("t3_stall_ready", CMPW'(req_ready), '0);
        applyStimulus('0, 4'b1111);
        waitDrain(20);
        applyStimulus(4'b0010, 4'b1111);
        checkOutput("t3_resume", CMPW'(req_ready), CMPW'(4'b0010));
        cycle();
        applyStimulus('0, 4'b1111);
        waitDrain(20);

        $display("[TB] test 4: spurious BAQ output");
        inject = 1'b1;
        cycle();
        inject = 1'b0;
        checkOutput("t4_err", CMPW'(err_sticky), CMPW'(1'b1));
        checkOutput("t4_no_push", CMPW'(rsp_valid), '0);
        applyStimulus(4'b0001, 4'b1111);
        cycle();
        applyStimulus('0, 4'b1111);
        waitDrain(20);
        checkOutput("t4_err_hold", CMPW'(err_sticky), CMPW'(1'b1));

        $display("[TB] test 5: reset with packets in flight");
        applyStimulus(4'b0001, 4'b0000);
        cycle();
        applyStimulus('0, 4'b0000);
        cycle();
        cycle();
        applyStimulus(4'b0010, 4'b0000);
        cycle();
        applyStimulus(4'b0100, 4'b0000);
        cycle();
        applyStimulus('0, 4'b0000);
        checkOutput("t5_queued", CMPW'(rsp_valid), CMPW'(4'b0001));
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        sb.delete();
        exp_ptr = 0;
        checkOutput("t5_rsp_valid", CMPW'(rsp_valid), '0);
        checkOutput("t5_rsp_pack", CMPW'(rsp_pack), '0);
        checkOutput("t5_aggr_valid", CMPW'(aggr_valid), '0);
        checkOutput("t5_aggr_pack", CMPW'(aggr_pack), '0);
        checkOutput("t5_err", CMPW'(err_sticky), '0);
        checkOutput("t5_req_ready", CMPW'(req_ready), '0);
        applyStimulus('0, 4'b1111);
        repeat (6) cycle();
        hs_count = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, 4'b0000);
            cycle();
        end
        checkOutput("t5_credits", CMPW'(hs_count), CMPW'(FIFO_DEPTH));
        applyStimulus('0, 4'b1111);
        waitDrain(20);

        $display("[TB] test 6: pointer wrap");
        applyStimulus(4'b0100, 4'b1111);
        cycle();
        applyStimulus(4'b0100, 4'b1111);
        checkOutput("t6_wrap", CMPW'(req_ready), CMPW'(4'b0100));
        cycle();
        applyStimulus(4'b1111, 4'b1111);
        checkOutput("t6_ptr", CMPW'(req_ready), CMPW'(4'b1000));
        cycle();
        applyStimulus('0, 4'b1111);
        waitDrain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
